// File: rtl/pc_gen_unit.sv
// Program-counter generator for the RV32I fetch stage: owns the PC, selects
// trap / redirect / hold / sequential next-PC and handshakes the PC to fetch.
module pc_gen_unit #(
  parameter int unsigned         XLEN         = 32,
  parameter logic [XLEN-1:0]     RESET_VECTOR = '0,
  parameter int unsigned         INC          = 4,
  parameter int unsigned         ALIGN_BITS   = 2,
  parameter int unsigned         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             resume,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus_inc,
  output logic             pc_valid,
  output logic             misalign_err,
  output logic [XLEN-1:0]  bad_target,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Mask form keeps the alignment test legal even when ALIGN_BITS is 0.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t           state, state_next;
  logic [XLEN-1:0]  pc_next;
  logic [XLEN-1:0]  bad_next;
  logic             err_next;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             target_aligned;

  assign pc_valid       = (state == RUN);
  assign pc_plus_inc    = pc + XLEN'(INC);
  assign accept         = pc_valid && fetch_ready && !stall;
  assign target_aligned = (redirect_target & ALIGN_MASK) == '0;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    err_next   = 1'b0;
    bad_next   = bad_target;
    cnt_next   = accept ? fetch_count + CNT_W'(1) : fetch_count;

    unique case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (trap_valid) begin
          pc_next = trap_vector;
        end else if (redirect_valid) begin
          if (target_aligned) begin
            pc_next = redirect_target;
          end else begin
            err_next   = 1'b1;
            bad_next   = redirect_target;
            state_next = HALT;
          end
        end else if (accept) begin
          pc_next = pc_plus_inc;
        end
      end
      HALT: begin
        if (trap_valid) begin
          pc_next    = trap_vector;
          state_next = RUN;
        end else if (resume) begin
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      misalign_err <= 1'b0;
      bad_target   <= '0;
      fetch_count  <= '0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      misalign_err <= err_next;
      bad_target   <= bad_next;
      fetch_count  <= cnt_next;
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed scenarios then random traffic,
// each cycle's expected outputs come from a behavioural model and are queued.
module tb_pc_gen_unit;

  logic        clk;
  logic        rst;
  logic        fetch_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic        pc_valid;
  logic        misalign_err;
  logic [31:0] bad_target;
  logic [31:0] fetch_count;

  pc_gen_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .INC(4), .ALIGN_BITS(2), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .resume(resume),
    .pc(pc), .pc_plus_inc(pc_plus_inc), .pc_valid(pc_valid),
    .misalign_err(misalign_err), .bad_target(bad_target), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic [31:0] pc;
    logic [31:0] plus;
    logic        valid;
    logic        err;
    logic [31:0] bad;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned step_no = 0;

  // Behavioural model: mode 0 = boot, 1 = run, 2 = halted.
  int unsigned m_mode = 0;
  logic [31:0] m_pc = 32'h0;
  logic        m_err = 1'b0;
  logic [31:0] m_bad = 32'h0;
  logic [31:0] m_cnt = 32'h0;

  task automatic model_step();
    m_err = 1'b0;
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_bad = 32'h0; m_cnt = 32'h0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (fetch_ready && !stall) m_cnt = m_cnt + 32'd1;
      if (trap_valid) m_pc = trap_vector;
      else if (redirect_valid) begin
        if (redirect_target % 4 == 0) m_pc = redirect_target;
        else begin
          m_err = 1'b1; m_bad = redirect_target; m_mode = 2;
        end
      end else if (fetch_ready && !stall) m_pc = m_pc + 32'd4;
    end else begin
      if (trap_valid) begin
        m_pc = trap_vector; m_mode = 1;
      end else if (resume) m_mode = 1;
    end
  endtask

  task automatic drive(input logic r, input logic fr, input logic st,
                       input logic rv, input logic [31:0] rt,
                       input logic tv, input logic [31:0] tvec, input logic res);
    exp_t e;
    rst = r; fetch_ready = fr; stall = st;
    redirect_valid = rv; redirect_target = rt;
    trap_valid = tv; trap_vector = tvec; resume = res;
    model_step();
    e.idx = step_no; e.pc = m_pc; e.plus = m_pc + 32'd4; e.valid = (m_mode == 1);
    e.err = m_err; e.bad = m_bad; e.cnt = m_cnt;
    exp_q.push_back(e);
    step_no++;
    @(negedge clk);
  endtask

  task automatic cmp(input string name, input int unsigned idx,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, req);
    end
  endtask

  // Monitor: every clock edge the DUT presents a new state; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("pc", e.idx, pc, e.pc);
        cmp("pc_plus_inc", e.idx, pc_plus_inc, e.plus);
        cmp("pc_valid", e.idx, {31'd0, pc_valid}, {31'd0, e.valid});
        cmp("misalign_err", e.idx, {31'd0, misalign_err}, {31'd0, e.err});
        cmp("bad_target", e.idx, bad_target, e.bad);
        cmp("fetch_count", e.idx, fetch_count, e.cnt);
      end
    end
  end

  initial begin
    logic [31:0] t;
    int unsigned guard;
    // reset then free run: boot cycle, then 0,4,8,C,10
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) drive(0, 1, 0, 0, 0, 0, 0, 0);
    // stall 3, backpressure 2 at 0x10, then advance to 0x20
    repeat (3) drive(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) drive(0, 1, 0, 0, 0, 0, 0, 0);
    // redirect over stall, then release
    drive(0, 1, 1, 1, 32'h100, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    // misaligned redirect, idle in halt, ignored redirect, resume
    drive(0, 1, 0, 1, 32'h102, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 32'h300, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    // trap beats redirect; then trap out of halt (with resume too)
    drive(0, 1, 0, 1, 32'h200, 1, 32'h80, 0);
    drive(0, 1, 0, 1, 32'h102, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 32'h80, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    // trap with misaligned redirect: no error
    drive(0, 1, 0, 1, 32'h203, 1, 32'h40, 0);
    // wrap-around, then reset during redirect
    drive(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 32'h400, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      if ($urandom_range(3, 0) != 0) t[1:0] = 2'b00;
      drive(($urandom_range(99, 0) == 0), ($urandom_range(3, 0) != 0),
            ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0), t,
            ($urandom_range(19, 0) == 0), $urandom, ($urandom_range(3, 0) == 0));
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
